// File: rtl/async_sram_seq_phy_if.sv
// Request/response bus between the system bus bridge and the async SRAM PHY.
interface async_sram_seq_phy_if #(
  parameter int unsigned N_SRAM_A  = 18,
  parameter int unsigned N_SRAM_DQ = 16
);
  localparam int unsigned N_LANE = N_SRAM_DQ / 8;

  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [N_SRAM_A-1:0]  req_addr;
  logic [N_SRAM_DQ-1:0] req_wdata;
  logic [N_LANE-1:0]    req_byte_en;
  logic                 rsp_valid;
  logic [N_SRAM_DQ-1:0] rsp_rdata;

  modport master (
    output req_valid, req_write, req_addr, req_wdata, req_byte_en,
    input  req_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, req_byte_en,
    output req_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/async_sram_seq_phy.sv
// Async SRAM PHY: sequences single-word accesses through programmable
// setup/pulse/hold phases with fully registered pad outputs.
module async_sram_seq_phy #(
  parameter int unsigned N_SRAM_A  = 18,
  parameter int unsigned N_SRAM_DQ = 16,
  parameter int unsigned W_TIMING  = 4,
  localparam int unsigned N_LANE   = N_SRAM_DQ / 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [W_TIMING-1:0]  cfg_setup,
  input  logic [W_TIMING-1:0]  cfg_pulse,
  input  logic [W_TIMING-1:0]  cfg_hold,
  async_sram_seq_phy_if.slave  bus,
  input  logic [N_SRAM_DQ-1:0] padin_sram_dq,
  output logic [N_SRAM_DQ-1:0] padout_sram_dq,
  output logic [N_SRAM_DQ-1:0] padoe_sram_dq,
  output logic [N_SRAM_A-1:0]  padout_sram_a,
  output logic                 padout_sram_cs_n,
  output logic                 padout_sram_oe_n,
  output logic                 padout_sram_we_n,
  output logic [N_LANE-1:0]    padout_sram_byte_n
);

  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

  state_t               state_q, state_d;
  logic [W_TIMING-1:0]  cnt_q, cnt_d;
  logic [W_TIMING-1:0]  pulse_q, pulse_d;
  logic [W_TIMING-1:0]  hold_q, hold_d;
  logic                 wr_q, wr_d;
  logic [N_LANE-1:0]    be_q, be_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [N_SRAM_DQ-1:0] rsp_rdata_q, rsp_rdata_d;
  logic [N_SRAM_DQ-1:0] dq_q, dq_d;
  logic [N_SRAM_DQ-1:0] oe_q, oe_d;
  logic [N_SRAM_A-1:0]  a_q, a_d;
  logic                 cs_n_q, cs_n_d;
  logic                 oe_n_q, oe_n_d;
  logic                 we_n_q, we_n_d;
  logic [N_LANE-1:0]    byte_n_q, byte_n_d;

  // Expand per-lane enables into a per-bit mask.
  function automatic logic [N_SRAM_DQ-1:0] lane_mask(input logic [N_LANE-1:0] be);
    logic [N_SRAM_DQ-1:0] m;
    m = '0;
    for (int l = 0; l < int'(N_LANE); l++) m[l*8 +: 8] = {8{be[l]}};
    return m;
  endfunction

  // Next-state and next pad values; pads are loaded on the edge entering a state.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    pulse_d     = pulse_q;
    hold_d      = hold_q;
    wr_d        = wr_q;
    be_d        = be_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    dq_d        = dq_q;
    oe_d        = oe_q;
    a_d         = a_q;
    cs_n_d      = cs_n_q;
    oe_n_d      = oe_n_q;
    we_n_d      = we_n_q;
    byte_n_d    = byte_n_q;

    unique case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          state_d  = SETUP;
          cnt_d    = cfg_setup;
          pulse_d  = cfg_pulse;
          hold_d   = cfg_hold;
          wr_d     = bus.req_write;
          be_d     = bus.req_byte_en;
          a_d      = bus.req_addr;
          cs_n_d   = 1'b0;
          oe_n_d   = bus.req_write;
          we_n_d   = 1'b1;
          byte_n_d = ~bus.req_byte_en;
          if (bus.req_write) begin
            dq_d = bus.req_wdata;
            oe_d = lane_mask(bus.req_byte_en);
          end
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = PULSE;
          cnt_d   = pulse_q;
          we_n_d  = ~wr_q;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      PULSE: begin
        if (cnt_q == '0) begin
          state_d = HOLD;
          cnt_d   = hold_q;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (!wr_q) begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = padin_sram_dq & lane_mask(be_q);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d  = IDLE;
          cs_n_d   = 1'b1;
          oe_n_d   = 1'b1;
          we_n_d   = 1'b1;
          byte_n_d = '1;
          oe_d     = '0;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      pulse_q     <= '0;
      hold_q      <= '0;
      wr_q        <= 1'b0;
      be_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      dq_q        <= '0;
      oe_q        <= '0;
      a_q         <= '0;
      cs_n_q      <= 1'b1;
      oe_n_q      <= 1'b1;
      we_n_q      <= 1'b1;
      byte_n_q    <= '1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pulse_q     <= pulse_d;
      hold_q      <= hold_d;
      wr_q        <= wr_d;
      be_q        <= be_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      dq_q        <= dq_d;
      oe_q        <= oe_d;
      a_q         <= a_d;
      cs_n_q      <= cs_n_d;
      oe_n_q      <= oe_n_d;
      we_n_q      <= we_n_d;
      byte_n_q    <= byte_n_d;
    end
  end

  // Ready is decoded from state so IDLE always lasts at least one cycle.
  assign bus.req_ready      = (state_q == IDLE) && !rst;
  assign bus.rsp_valid      = rsp_valid_q;
  assign bus.rsp_rdata      = rsp_rdata_q;
  assign padout_sram_dq     = dq_q;
  assign padoe_sram_dq      = oe_q;
  assign padout_sram_a      = a_q;
  assign padout_sram_cs_n   = cs_n_q;
  assign padout_sram_oe_n   = oe_n_q;
  assign padout_sram_we_n   = we_n_q;
  assign padout_sram_byte_n = byte_n_q;

endmodule

// File: tb/tb_async_sram_seq_phy.sv
// Directed bench for async_sram_seq_phy: 16-bit and 32-bit instances.
module tb_async_sram_seq_phy;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [3:0] cfg_setup = '0, cfg_pulse = '0, cfg_hold = '0;
  always #5 clk = ~clk;

  async_sram_seq_phy_if #(.N_SRAM_A(18), .N_SRAM_DQ(16)) bus16 ();
  async_sram_seq_phy_if #(.N_SRAM_A(18), .N_SRAM_DQ(32)) bus32 ();

  logic [15:0] pin16, pout16, poe16;
  logic [17:0] pa16;
  logic        cs16, oen16, wen16;
  logic [1:0]  bn16;
  logic [31:0] pin32, pout32, poe32;
  logic [17:0] pa32;
  logic        cs32, oen32, wen32;
  logic [3:0]  bn32;

  async_sram_seq_phy #(.N_SRAM_A(18), .N_SRAM_DQ(16), .W_TIMING(4)) dut16 (
    .clk(clk), .rst(rst), .cfg_setup(cfg_setup), .cfg_pulse(cfg_pulse), .cfg_hold(cfg_hold),
    .bus(bus16), .padin_sram_dq(pin16), .padout_sram_dq(pout16), .padoe_sram_dq(poe16),
    .padout_sram_a(pa16), .padout_sram_cs_n(cs16), .padout_sram_oe_n(oen16),
    .padout_sram_we_n(wen16), .padout_sram_byte_n(bn16));

  async_sram_seq_phy #(.N_SRAM_A(18), .N_SRAM_DQ(32), .W_TIMING(4)) dut32 (
    .clk(clk), .rst(rst), .cfg_setup(cfg_setup), .cfg_pulse(cfg_pulse), .cfg_hold(cfg_hold),
    .bus(bus32), .padin_sram_dq(pin32), .padout_sram_dq(pout32), .padoe_sram_dq(poe32),
    .padout_sram_a(pa32), .padout_sram_cs_n(cs32), .padout_sram_oe_n(oen32),
    .padout_sram_we_n(wen32), .padout_sram_byte_n(bn32));

  int checks = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept16(input logic wr, input logic [17:0] addr,
                          input logic [15:0] wdata, input logic [1:0] be);
    bus16.req_write = wr;  bus16.req_addr = addr;
    bus16.req_wdata = wdata; bus16.req_byte_en = be;
    bus16.req_valid = 1'b1;
    tick();
    bus16.req_valid = 1'b0;
  endtask

  initial begin
    int n;
    bit seen;
    bus16.req_valid = 1'b0; bus16.req_write = 1'b0; bus16.req_addr = '0;
    bus16.req_wdata = '0;   bus16.req_byte_en = '0;
    bus32.req_valid = 1'b0; bus32.req_write = 1'b0; bus32.req_addr = '0;
    bus32.req_wdata = '0;   bus32.req_byte_en = '0;
    pin16 = '0; pin32 = '0;

    // Reset values
    tick(); tick();
    check("rst_ready", 32'(bus16.req_ready), 0);
    check("rst_cs_n", 32'(cs16), 1);
    check("rst_oe_we_n", 32'({oen16, wen16}), 32'h3);
    check("rst_byte_n", 32'(bn16), 32'h3);
    check("rst_padoe", 32'(poe16), 0);
    check("rst_dq_addr", 32'({pout16, pa16}), 0);
    check("rst_rsp", 32'({bus16.rsp_valid, bus16.rsp_rdata}), 0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 32'(bus16.req_ready), 1);

    // Read 0x1234, cfg 0/1/0, pad 0xBEEF
    cfg_setup = 4'd0; cfg_pulse = 4'd1; cfg_hold = 4'd0;
    pin16 = 16'hBEEF;
    accept16(1'b0, 18'h1234, 16'h0000, 2'b11);
    check("rd_c1_cs_oe", 32'({cs16, oen16, wen16}), 32'b001);
    check("rd_c1_addr", 32'(pa16), 32'h1234);
    check("rd_c1_byte_n", 32'(bn16), 0);
    check("rd_c1_padoe", 32'(poe16), 0);
    check("rd_c1_ready", 32'(bus16.req_ready), 0);
    tick();
    check("rd_c2_oe_n", 32'(oen16), 0);
    tick();
    check("rd_c3_rsp_valid", 32'(bus16.rsp_valid), 0);
    tick();
    check("rd_c4_rsp_valid", 32'(bus16.rsp_valid), 1);
    check("rd_c4_rdata", 32'(bus16.rsp_rdata), 32'hBEEF);
    check("rd_c4_cs_oe", 32'({cs16, oen16}), 32'b01);
    tick();
    check("rd_c5_ready", 32'(bus16.req_ready), 1);
    check("rd_c5_cs_n", 32'(cs16), 1);
    check("rd_c5_rsp_valid", 32'(bus16.rsp_valid), 0);
    check("rd_c5_rdata_hold", 32'(bus16.rsp_rdata), 32'hBEEF);

    // Write 0xA5C3, byte_en 2'b10, cfg 1/2/1
    cfg_setup = 4'd1; cfg_pulse = 4'd2; cfg_hold = 4'd1;
    accept16(1'b1, 18'h0042, 16'hA5C3, 2'b10);
    for (int c = 1; c <= 7; c++) begin
      check($sformatf("wr_c%0d_byte_n", c), 32'(bn16), 32'b01);
      check($sformatf("wr_c%0d_padoe", c), 32'(poe16), 32'hFF00);
      check($sformatf("wr_c%0d_dq", c), 32'(pout16), 32'hA5C3);
      check($sformatf("wr_c%0d_we_n", c), 32'(wen16), (c >= 3 && c <= 5) ? 32'd0 : 32'd1);
      check($sformatf("wr_c%0d_rsp_valid", c), 32'(bus16.rsp_valid), 0);
      tick();
    end
    check("wr_c8_idle", 32'({bus16.req_ready, cs16, poe16}), 32'h30000);

    // Back-to-back write then read with valid held high, cfg 0/0/0
    cfg_setup = 4'd0; cfg_pulse = 4'd0; cfg_hold = 4'd0;
    pin16 = 16'h5A5A;
    bus16.req_write = 1'b1; bus16.req_addr = 18'h22; bus16.req_wdata = 16'h1111;
    bus16.req_byte_en = 2'b11; bus16.req_valid = 1'b1;
    tick();
    bus16.req_write = 1'b0; bus16.req_addr = 18'h33;
    tick();
    check("b2b_c2_we_n", 32'(wen16), 0);
    tick();
    check("b2b_c3_hold", 32'({bus16.req_ready, wen16, poe16}), 32'h1FFFF);
    tick();
    check("b2b_c4_idle", 32'({bus16.req_ready, oen16, cs16, poe16}), 32'h70000);
    tick();
    bus16.req_valid = 1'b0;
    check("b2b_c5_read", 32'({bus16.req_ready, oen16, poe16}), 0);
    check("b2b_c5_addr", 32'(pa16), 32'h33);
    tick(); tick();
    check("b2b_c7_rsp", 32'({bus16.rsp_valid, bus16.rsp_rdata}), 32'h15A5A);
    tick();

    // Config changed mid-access only affects the next access
    cfg_pulse = 4'd1;
    for (int k = 0; k < 2; k++) begin
      accept16(1'b1, 18'h7, 16'h00FF, 2'b01);
      if (k == 0) cfg_pulse = 4'd7;
      n = 0;
      for (int i = 0; i < 40 && !bus16.req_ready; i++) begin
        if (!wen16) n++;
        tick();
      end
      check($sformatf("cfg_pulse_len_%0d", k), 32'(n), (k == 0) ? 32'd2 : 32'd8);
    end

    // byte_en = 0 read returns zero and never drives pads
    cfg_setup = 4'd0; cfg_pulse = 4'd0; cfg_hold = 4'd0;
    pin16 = 16'hFFFF;
    accept16(1'b0, 18'h9, 16'h0, 2'b00);
    check("be0_c1", 32'({bn16, poe16, cs16}), 32'h60000);
    tick(); tick();
    check("be0_c3_rsp", 32'({bus16.rsp_valid, bus16.rsp_rdata}), 32'h10000);
    tick();

    // 32-bit instance, cfg 15/15/15, single-lane read
    cfg_setup = 4'd15; cfg_pulse = 4'd15; cfg_hold = 4'd15;
    pin32 = 32'hDEADBEEF;
    bus32.req_write = 1'b0; bus32.req_addr = 18'h100; bus32.req_byte_en = 4'b0100;
    bus32.req_valid = 1'b1;
    tick();
    bus32.req_valid = 1'b0;
    n = 1;
    check("w32_c1_byte_n", 32'(bn32), 32'b1011);
    check("w32_c1_oe", 32'({cs32, oen32, poe32 == 32'h0}), 32'b001);
    while (!bus32.rsp_valid && n < 100) begin tick(); n++; end
    check("w32_rsp_cycle", 32'(n), 32'd33);
    check("w32_rdata", bus32.rsp_rdata, 32'h00AD0000);
    while (!bus32.req_ready && n < 100) begin tick(); n++; end
    check("w32_idle_cycle", 32'(n), 32'd49);

    // Reset during PULSE of a read
    cfg_setup = 4'd0; cfg_pulse = 4'd3; cfg_hold = 4'd0;
    pin16 = 16'h1357;
    accept16(1'b0, 18'h55, 16'h0, 2'b11);
    tick();
    check("rstmid_c2_oe_n", 32'(oen16), 0);
    rst = 1'b1;
    tick();
    check("rstmid_pads", 32'({cs16, oen16, wen16, bn16, poe16}), 32'h1F0000);
    check("rstmid_ready", 32'(bus16.req_ready), 0);
    rst = 1'b0;
    #1;
    check("rstmid_ready_after", 32'(bus16.req_ready), 1);
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (bus16.rsp_valid) seen = 1'b1;
      tick();
    end
    check("rstmid_no_rsp", 32'(seen), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/async_sram_seq_phy.md
Name: async_sram_seq_phy

Overview:
- Next-generation external async SRAM PHY with a built-in access sequencer.
- Accepts single-word read/write requests over a valid/ready handshake.
- Generates CS/OE/WE/byte strobes with per-access programmable setup/pulse/hold cycle counts, and returns read data over a response strobe.
- Parametrised in address width and data width (1-4 byte lanes); all pad-facing signals are registered. Sits between the system bus bridge and the pad ring.

Parameters:
- N_SRAM_A, 18, SRAM address width.
- N_SRAM_DQ, 16, data width; must be 8, 16, 24 or 32. Byte lanes N_LANE = N_SRAM_DQ/8.
- W_TIMING, 4, width of each timing config field.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- cfg_setup  in  W_TIMING  setup phase length minus 1.
- cfg_pulse  in  W_TIMING  strobe phase length minus 1.
- cfg_hold  in  W_TIMING  hold phase length minus 1.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid&&ready.
- req_write  in  1  1=write, 0=read.
- req_addr  in  N_SRAM_A  word address.
- req_wdata  in  N_SRAM_DQ  write data.
- req_byte_en  in  N_LANE  active-high lane enables.
- rsp_valid  out  1  one-cycle read-data strobe; no backpressure.
- rsp_rdata  out  N_SRAM_DQ  read data, valid with rsp_valid.
- padin_sram_dq  in  N_SRAM_DQ  DQ pad inputs.
- padout_sram_dq  out  N_SRAM_DQ  DQ pad outputs.
- padoe_sram_dq  out  N_SRAM_DQ  DQ pad output enables, per bit.
- padout_sram_a  out  N_SRAM_A  address.
- padout_sram_cs_n  out  1  chip select.
- padout_sram_oe_n  out  1  output enable.
- padout_sram_we_n  out  1  write enable.
- padout_sram_byte_n  out  N_LANE  active-low byte strobes; bit 0 = DQ[7:0].

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high. All logic is posedge `clk`.
- States: IDLE, SETUP, PULSE, HOLD.
- Pad registers are loaded on the edge entering a state, so pins show that state's values for its whole duration.
- Reset values: req_ready=0 while rst, then 1 in IDLE; rsp_valid=0; rsp_rdata=0; cs_n=1; oe_n=1; we_n=1; byte_n all 1; padoe all 0; padout_sram_dq=0; addr=0.
- IDLE:
  - req_ready=1 (combinational from state).
  - cs_n/oe_n/we_n=1, byte_n all 1, padoe=0; addr and dq_out hold their last values.
  - On valid&&ready: latch write, addr, wdata, byte_en, cfg_setup, cfg_pulse, cfg_hold; go to SETUP.
- Config is captured at acceptance only. Changes mid-access have no effect.
- Phase lengths: SETUP lasts cfg_setup+1 cycles, PULSE lasts cfg_pulse+1 cycles, HOLD lasts cfg_hold+1 cycles. Use a single down-counter of W_TIMING bits, reloaded on each phase entry. Maximum value gives 2^W_TIMING cycles with no wrap error.
- req_ready=0 in SETUP, PULSE and HOLD. Minimum access is 4 cycles including IDLE.
- Strobe values by state:
  - SETUP: cs_n=0; addr valid; byte_n=~byte_en; we_n=1. Read: oe_n=0. Write: oe_n=1, dq_out=wdata, and padoe bits of enabled lanes=1 (disabled lanes 0).
  - PULSE: as SETUP, plus we_n=0 for writes.
  - HOLD: we_n=1, oe_n=1, cs_n=0; write data and padoe remain driven; byte_n unchanged.
  - HOLD→IDLE: strobes deassert, padoe=0.
- Read capture:
  - padin is registered on the edge ending the last PULSE cycle.
  - rsp_valid=1 during the first HOLD cycle, with rsp_rdata = that sample.
  - Disabled lanes read as 0.
  - Writes never raise rsp_valid.
- Bus turnaround: the mandatory IDLE cycle guarantees padoe=0 for at least one cycle before oe_n falls on a following read.
- byte_en=0: access still runs with full timing; all byte_n stay 1; padoe=0; a read returns 0.
- Reset mid-access: on the edge with rst=1, the FSM goes to IDLE and all pads take reset values; no rsp_valid for the aborted access.
- rsp_rdata holds its value until the next read capture.

Test Plan:
- Reset with a read in PULSE → next cycle cs_n=1, oe_n=1, padoe=0, rsp_valid never pulses; req_ready=1 the first cycle after rst falls.
- N_SRAM_DQ=16, cfg 0/1/0, read addr 0x1234, byte_en=2'b11, pad drives 0xBEEF, accept at edge 0 →
  - cycle 1 SETUP: cs_n=0, oe_n=0;
  - cycles 2-3 PULSE;
  - cycle 4 HOLD: rsp_valid=1, rsp_rdata=0xBEEF;
  - cycle 5 IDLE: req_ready=1.
- Write 0xA5C3, byte_en=2'b10, cfg 1/2/1 → byte_n=2'b01, padoe=0xFF00, dq_out=0xA5C3 for cycles 1-7; we_n=0 exactly cycles 3-5; rsp_valid stays 0.
- Back-to-back write then read, valid held high → at least one IDLE cycle with padoe=0 before oe_n=0; second req_ready pulse occurs after the write's HOLD.
- Change cfg_pulse from 1 to 7 during an access → current access keeps 2 PULSE cycles; next access uses 8.
- N_SRAM_DQ=32, cfg 15/15/15, read with byte_en=4'b0100 → each phase lasts 16 cycles; byte_n=4'b1011; rsp_rdata = pad bits [23:16] only, others 0.
